mod_quad_gate_tester: RTL and testbench
=======================================

# mod_quad_gate_tester

Synthesizable sequencer that drives and checks a quad 2-input gate package (74x08/00/32/86 class), acting as the other end of the gate's A/B/Y pin interface. It drives all 256 A/B input combinations onto the four gates, waits a settle interval, samples Y and compares it against the selected logic function. It reports pass/fail, a mismatch count, the first failing vector and which gates failed. It sits beside the chip models, or on a board, as an in-circuit part checker.

## Interface
- SETTLE, default 4: wait cycles between driving a vector and sampling Y; legal range 1..255.
- CLK  in  1  rising-edge clock.
- CLR_N  in  1  asynchronous active-low reset.
- START  in  1  begin a run; sampled only in IDLE or FIN.
- FUNC  in  2  expected function: 00 AND, 01 NAND, 10 OR, 11 XOR; latched at START.
- A  out  [0:3]  gate A inputs; bit n feeds gate n.
- B  out  [0:3]  gate B inputs.
- Y  in  [0:3]  gate outputs under test.
- BUSY  out  1  run in progress.
- DONE  out  1  run complete; held until the next START or reset.
- PASS  out  1  valid when DONE: 1 iff ERR_CNT==0.
- ERR_CNT  out  8  mismatching vectors; saturates at 255.
- FIRST_FAIL  out  8  {A,B} of the first mismatching vector.
- FAIL_BITS  out  [0:3]  sticky OR of per-gate mismatches.

## Operation
- Reset (CLR_N low, asynchronous): state IDLE; A, B, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FAIL_BITS all 0. Reset mid-run aborts immediately; the next START begins from vector 0.
- Vector counter V is 8-bit unsigned, 0..255, incrementing by 1. A = V[7:4], B = V[3:0], with A[0]/B[0] as the MSB.
- States:
  - IDLE → WAIT on START. Clears statistics, latches FUNC, drives V=0, sets BUSY.
  - WAIT: loads the down-counter with SETTLE on entry; → CHECK when it expires.
  - CHECK: computes E = FUNC(A,B) bitwise and M = E ^ Ysampled.
    - If M≠0: ERR_CNT increments (saturating); FAIL_BITS |= M; if this is the first mismatch, FIRST_FAIL = {A,B}.
    - If V==255 → FIN. Otherwise V+1 is driven → WAIT.
  - FIN: BUSY=0, DONE=1, PASS=(ERR_CNT==0). START → same action as from IDLE; DONE drops in that cycle.
- START while BUSY is ignored. FUNC changes while BUSY are ignored.
- A and B are registered outputs and change only on a vector transition.

## Timing
- START sampled at edge 0; vector 0 appears after edge 0.
- Vector i is compared at edge (i+1)·(SETTLE+1); vector i+1 is driven after the same edge.
- DONE/PASS rise and BUSY falls after edge 256·(SETTLE+1). For SETTLE=4 this is edge 1280.
- Y is sampled combinationally at the CHECK edge. Y must be stable SETTLE+1 cycles after the A/B change.
- ERR_CNT, FIRST_FAIL and FAIL_BITS update at the CHECK edge and are stable once DONE=1.

## Configuration
- QGT_Y_SYNC_EN defined: Y passes through a 2-flop synchronizer before comparison. WAIT lengthens by 2 cycles, so the per-vector period is SETTLE+3 and DONE rises after 256·(SETTLE+3) edges. Synchronizer flops reset to 0.
- QGT_Y_SYNC_EN undefined: no synchronizer; timing is as above.

## Structure
- Shared package quad_gate_test_pkg holds:
  - FUNC encodings: FN_AND=2'b00, FN_NAND=2'b01, FN_OR=2'b10, FN_XOR=2'b11.
  - State encoding: IDLE, WAIT, CHECK, FIN.
  - NVEC=256.
- Sub-module mod_gate_ref: combinational 4-bit expected-value model with inputs FUNC, A, B and output E. It is reused by chip-model benches.
- The top module holds the FSM, settle counter, vector counter, statistics and the optional synchronizer.

## Test plan
- Ideal 74x08 model attached, FUNC=00, SETTLE=4, one START pulse → DONE after edge 1280; PASS=1, ERR_CNT=0, FAIL_BITS=0000, BUSY low afterwards.
- AND model with Y[2] stuck at 1, FUNC=00 → ERR_CNT=192, FAIL_BITS=0010, FIRST_FAIL=8'h00, PASS=0.
- Ideal AND model with FUNC=11 (XOR) → mismatch whenever A[n]|B[n]; ERR_CNT=255 (saturated at 255 out of 255 failing vectors), FAIL_BITS=1111, FIRST_FAIL=8'h01.
- CLR_N pulsed low at edge 600, then START → all outputs 0 during reset; the fresh run completes at edge 1280 after START with PASS=1.
- START pulsed at edge 100 during a run, and FUNC toggled mid-run → no restart and the latched FUNC is kept; DONE still rises at edge 1280. START in FIN restarts, and DONE falls in that cycle.
- With QGT_Y_SYNC_EN and SETTLE=1, ideal 74x32 with FUNC=10 → DONE after edge 1024, PASS=1.

Source files
------------

// File: rtl/quad_gate_test_pkg.sv
// Shared definitions for the quad 2-input gate tester: function codes, FSM states
// and the per-gate reference function.
package quad_gate_test_pkg;

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_NAND = 2'b01;
    localparam logic [1:0] FN_OR   = 2'b10;
    localparam logic [1:0] FN_XOR  = 2'b11;

    localparam int NVEC = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_FIN
    } state_t;

    function automatic logic gate_fn(input logic [1:0] func, input logic a, input logic b);
        logic r;
        case (func)
            FN_AND:  r = a & b;
            FN_NAND: r = ~(a & b);
            FN_OR:   r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mod_gate_ref.sv
// Combinational expected-output model of a quad 2-input gate package; gate n is
// fed by bit n of A and B.
module mod_gate_ref
    import quad_gate_test_pkg::*;
(
    input  logic [1:0] i_func,
    input  logic [0:3] i_a,
    input  logic [0:3] i_b,
    output logic [0:3] o_e
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_gate
        assign o_e[gi] = gate_fn(i_func, i_a[gi], i_b[gi]);
    end

endmodule

// File: rtl/mod_quad_gate_tester.sv
// In-circuit quad 2-input gate checker: sweeps all 256 A/B vectors, samples Y after
// a settle interval and gathers mismatch statistics. Optional QGT_Y_SYNC_EN adds a
// 2-flop synchronizer on Y and stretches each wait by two cycles.
module mod_quad_gate_tester
    import quad_gate_test_pkg::*;
#(
    parameter int unsigned SETTLE = 4
)
(
    input  logic       i_clk,
    input  logic       i_clr_n,
    input  logic       i_start,
    input  logic [1:0] i_func,
    output logic [0:3] o_a,
    output logic [0:3] o_b,
    input  logic [0:3] i_y,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_err_cnt,
    output logic [7:0] o_first_fail,
    output logic [0:3] o_fail_bits
);

    logic [0:3] w_y;

`ifdef QGT_Y_SYNC_EN
    localparam logic [8:0] WAIT_LEN = 9'(SETTLE + 2);

    logic [0:3] r_y_meta;
    logic [0:3] r_y_sync;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_y_meta <= '0;
            r_y_sync <= '0;
        end else begin
            r_y_meta <= i_y;
            r_y_sync <= r_y_meta;
        end
    end

    assign w_y = r_y_sync;
`else
    localparam logic [8:0] WAIT_LEN = 9'(SETTLE);

    assign w_y = i_y;
`endif

    state_t     r_state;
    logic [1:0] r_func;
    logic [7:0] r_vec;
    logic [8:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_err_cnt;
    logic [7:0] r_first_fail;
    logic [0:3] r_fail_bits;

    logic [0:3] w_e;
    logic [0:3] w_m;
    logic       w_mismatch;
    logic [7:0] w_err_next;

    assign o_a = r_vec[7:4];
    assign o_b = r_vec[3:0];

    mod_gate_ref u_ref (
        .i_func (r_func),
        .i_a    (o_a),
        .i_b    (o_b),
        .o_e    (w_e)
    );

    assign w_m        = w_e ^ w_y;
    assign w_mismatch = (w_m != 4'b0000);
    assign w_err_next = (w_mismatch && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state      <= ST_IDLE;
            r_func       <= FN_AND;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            r_fail_bits  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        r_state      <= ST_WAIT;
                        r_func       <= i_func;
                        r_vec        <= '0;
                        r_cnt        <= WAIT_LEN;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= '0;
                        r_first_fail <= '0;
                        r_fail_bits  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= 9'd1) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                ST_CHECK: begin
                    // The count only leaves zero on the first mismatch, so it doubles as the first-fail flag.
                    if (w_mismatch) begin
                        r_err_cnt   <= w_err_next;
                        r_fail_bits <= r_fail_bits | w_m;
                        if (r_err_cnt == 8'd0) begin
                            r_first_fail <= r_vec;
                        end
                    end
                    if (r_vec == 8'(NVEC - 1)) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 8'd0);
                    end else begin
                        r_state <= ST_WAIT;
                        r_vec   <= r_vec + 8'd1;
                        r_cnt   <= WAIT_LEN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_cnt    = r_err_cnt;
    assign o_first_fail = r_first_fail;
    assign o_fail_bits  = r_fail_bits;

endmodule

// File: tb/tb_mod_quad_gate_tester.sv
// Bench for mod_quad_gate_tester: attaches behavioural gate chips (ideal/faulty) to the
// A/B/Y pins, queues expected run results at START and compares them when DONE rises.
module tb_mod_quad_gate_tester;

`ifdef QGT_Y_SYNC_EN
    localparam int SETTLE = 1;
    localparam int PERIOD = SETTLE + 3;
`else
    localparam int SETTLE = 4;
    localparam int PERIOD = SETTLE + 1;
`endif
    localparam int RUN_EDGES = 256 * PERIOD;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [7:0] first;
        logic [3:0] fbits;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] func = 2'b00;
    logic [0:3] a, b, y;
    logic       busy, done, pass;
    logic [7:0] err_cnt, first_fail;
    logic [0:3] fail_bits;

    int chip_mode = 0;
    int n_checks = 0;
    int n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mod_quad_gate_tester #(.SETTLE(SETTLE)) dut (
        .i_clk        (clk),
        .i_clr_n      (clr_n),
        .i_start      (start),
        .i_func       (func),
        .o_a          (a),
        .o_b          (b),
        .i_y          (y),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_err_cnt    (err_cnt),
        .o_first_fail (first_fail),
        .o_fail_bits  (fail_bits)
    );

    // Chip under test: 0 = ideal 74x08, 1 = 74x08 with gate 2 output stuck high, 2 = ideal 74x32.
    function automatic logic [0:3] chip_y(input int mode, input logic [0:3] ca, input logic [0:3] cb);
        logic [0:3] r;
        case (mode)
            1:       r = (ca & cb) | 4'b0010;
            2:       r = ca | cb;
            default: r = ca & cb;
        endcase
        return r;
    endfunction

    always_comb y = chip_y(chip_mode, a, b);

    function automatic logic [0:3] truth(input logic [1:0] f, input logic [0:3] ta, input logic [0:3] tb);
        logic [0:3] r;
        case (f)
            2'b00:   r = ta & tb;
            2'b01:   r = ~(ta & tb);
            2'b10:   r = ta | tb;
            default: r = ta ^ tb;
        endcase
        return r;
    endfunction

    function automatic exp_t predict(input logic [1:0] f, input int mode);
        exp_t       e;
        logic [7:0] vv;
        logic [0:3] ma, mb, mm;
        int         fails;
        e = '0;
        fails = 0;
        for (int v = 0; v < 256; v++) begin
            vv = 8'(v);
            ma = vv[7:4];
            mb = vv[3:0];
            mm = truth(f, ma, mb) ^ chip_y(mode, ma, mb);
            if (mm != 4'b0000) begin
                if (fails == 0) e.first = vv;
                fails++;
                e.fbits = e.fbits | mm;
            end
        end
        e.err  = (fails > 255) ? 8'd255 : 8'(fails);
        e.pass = (fails == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 32'(a), 0);
        check({tag, "_b"}, 32'(b), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_err"}, 32'(err_cnt), 0);
        check({tag, "_first"}, 32'(first_fail), 0);
        check({tag, "_fbits"}, 32'(fail_bits), 0);
    endtask

    // One START transaction; poke_at pulses START with a toggled FUNC mid-run,
    // abort_at pulls CLR_N low right after that edge and abandons the run.
    task automatic do_run(input logic [1:0] f, input int mode, input int poke_at, input int abort_at);
        exp_t e;
        int   n;
        chip_mode = mode;
        if (abort_at == 0) sb_q.push_back(predict(f, mode));
        @(negedge clk);
        start = 1'b1;
        func  = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_vec0", 32'({a, b}), 0);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (poke_at != 0 && n == poke_at - 1) begin
                start = 1'b1;
                func  = ~f;
            end
            if (poke_at != 0 && n == poke_at) start = 1'b0;
            if (abort_at != 0 && n == abort_at) begin
                clr_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                clr_n = 1'b1;
                $display("run func=%b mode=%0d aborted at edge %0d", f, mode, n);
                return;
            end
            if (n == PERIOD) check("vec1", 32'({a, b}), 32'h01);
            if (done) break;
            if (n > RUN_EDGES + 20) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
        e = sb_q.pop_front();
        check("done_edge", 32'(n), 32'(RUN_EDGES));
        check("busy_after", 32'(busy), 0);
        check("pass", 32'(pass), 32'(e.pass));
        check("err_cnt", 32'(err_cnt), 32'(e.err));
        check("first_fail", 32'(first_fail), 32'(e.first));
        check("fail_bits", 32'(fail_bits), 32'(e.fbits));
        $display("run func=%b mode=%0d edges=%0d err=%0d first=%02h fbits=%b pass=%0b",
                 f, mode, n, err_cnt, first_fail, fail_bits, pass);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(posedge clk);

        do_run(2'b00, 0, 0, 0);    // ideal AND
        do_run(2'b00, 1, 0, 0);    // gate 2 stuck at 1
        do_run(2'b11, 0, 0, 0);    // AND part tested as XOR
        do_run(2'b00, 1, 0, 600);  // aborted by reset
        do_run(2'b00, 0, 0, 0);    // fresh run after reset
        do_run(2'b00, 0, 100, 0);  // START + FUNC change while busy

        repeat (3) @(posedge clk);
        #1;
        check("done_held", 32'(done), 1);
        check("pass_held", 32'(pass), 1);
        do_run(2'b10, 2, 0, 0);    // restart from FIN, ideal OR

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
